// File: rtl/fetch_pc_stage.sv
// -----------------------------------------------------------------------------
// fetch_pc_stage
//
// PC register and instruction-fetch stage. Issues word addresses to a
// synchronous instruction ROM (1-cycle read latency), buffers the returned
// instructions together with their PC in a 2-entry FIFO toward decode, and
// redirects fetch when the branch unit reports a taken branch.
//
// Ports:
//   clk         in   1      single clock, rising edge
//   reset       in   1      synchronous, active-high
//   pc_sel      in   1      branch taken; redirect request
//   br_pc       in   32     branch target; only [PC_W-1:2] used
//   imem_en     out  1      read strobe to instruction ROM
//   imem_addr   out  PC_W   byte address to ROM (word aligned)
//   imem_rdata  in   INS_W  ROM data, valid the cycle after imem_en
//   if_valid    out  1      head entry valid toward decode
//   if_ready    in   1      decode accepts head entry
//   if_pc       out  PC_W   PC of head entry
//   if_instr    out  INS_W  instruction of head entry
// -----------------------------------------------------------------------------
module fetch_pc_stage #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_sel,
  input  logic [31:0]      br_pc,
  output logic             imem_en,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [INS_W-1:0] imem_rdata,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [PC_W-1:0]  if_pc,
  output logic [INS_W-1:0] if_instr
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  inflight_pc;
  logic             inflight;

  logic [PC_W-1:0]  fifo_pc    [2];
  logic [INS_W-1:0] fifo_instr [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       cnt;

  logic             pop;
  logic             push;
  logic             issue;
  logic [2:0]       credit;
  logic [PC_W-1:0]  target;

  // State register: BOOT is held for exactly one cycle after reset so the
  // ROM never sees a strobe on the reset-release cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Handshake and issue logic. A redirect suppresses the head valid, the
  // pop, the issue and the push of returning wrong-path data in one go.
  // The credit counts buffered entries plus the one in flight, less the one
  // leaving this cycle, so an issued read always finds a free FIFO slot.
  always_comb begin
    target   = {br_pc[PC_W-1:2], 2'b00};
    if_valid = (cnt != 2'd0) && !pc_sel;
    pop      = if_valid && if_ready;
    push     = inflight && !pc_sel;
    credit   = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
    issue    = (state_q == RUN) && !pc_sel && (credit < 3'd2);
    imem_en  = issue;
    imem_addr = pc_q;
    if_pc    = fifo_pc[rd_ptr];
    if_instr = fifo_instr[rd_ptr];
  end

  // PC and in-flight tracking. inflight_pc remembers which address the ROM
  // is answering so the returning word can be tagged with its PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (pc_sel) begin
      pc_q     <= target;
      inflight <= 1'b0;
    end else if (issue) begin
      inflight    <= 1'b1;
      inflight_pc <= pc_q;
      pc_q        <= pc_q + PC_W'(4);
    end else begin
      inflight <= 1'b0;
    end
  end

  // Two-entry FIFO toward decode. A redirect empties it by resetting the
  // pointers; stale storage contents are harmless because valid is cnt-based.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else if (pc_sel) begin
      cnt    <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr]    <= inflight_pc;
        fifo_instr[wr_ptr] <= imem_rdata;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_stage
//
// Directed testbench for fetch_pc_stage. A behavioural synchronous ROM holds
// ROM[i] = i. Every accepted instruction is checked against the PC the bench
// expects next, so any lost, duplicated or stale entry shows up as a
// miscompare.
// -----------------------------------------------------------------------------
module tb_fetch_pc_stage;

  localparam int PC_W  = 9;
  localparam int INS_W = 32;

  logic             clk;
  logic             reset;
  logic             pc_sel;
  logic [31:0]      br_pc;
  logic             imem_en;
  logic [PC_W-1:0]  imem_addr;
  logic [INS_W-1:0] imem_rdata;
  logic             if_valid;
  logic             if_ready;
  logic [PC_W-1:0]  if_pc;
  logic [INS_W-1:0] if_instr;

  int               vectors;
  int               miscompares;
  int               delivered;
  logic [PC_W-1:0]  exp_pc;

  fetch_pc_stage #(.PC_W(PC_W), .INS_W(INS_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_sel     (pc_sel),
    .br_pc      (br_pc),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_pc      (if_pc),
    .if_instr   (if_instr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction ROM contents: word i holds the value i.
  function automatic logic [INS_W-1:0] romWord(input logic [PC_W-1:0] addr);
    return {{(INS_W-PC_W+2){1'b0}}, addr[PC_W-1:2]};
  endfunction

  // Synchronous ROM with one cycle of read latency; output holds when idle.
  always_ff @(posedge clk) begin
    if (imem_en) begin
      imem_rdata <= romWord(imem_addr);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               tag, actual, expected, $time);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then let the combinational
  // outputs settle before anything is sampled.
  task automatic applyStimulus(input logic rst, input logic sel,
                               input logic [31:0] br, input logic rdy);
    @(negedge clk);
    reset    = rst;
    pc_sel   = sel;
    br_pc    = br;
    if_ready = rdy;
    #1;
  endtask

  // One cycle plus in-order delivery check of whatever decode accepts.
  task automatic runCycle(input logic rst, input logic sel,
                          input logic [31:0] br, input logic rdy);
    applyStimulus(rst, sel, br, rdy);
    if (!rst && if_valid === 1'b1 && if_ready === 1'b1) begin
      checkOutput("deliver_pc", 32'(if_pc), 32'(exp_pc));
      checkOutput("deliver_instr", if_instr, romWord(exp_pc));
      exp_pc = exp_pc + PC_W'(4);
      delivered++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    delivered   = 0;
    exp_pc      = '0;
    reset       = 1'b1;
    pc_sel      = 1'b0;
    br_pc       = '0;
    if_ready    = 1'b1;

    // Reset values.
    runCycle(1'b1, 1'b0, 32'h0, 1'b1);
    runCycle(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("rst_imem_en", 32'(imem_en), 32'h0);
    checkOutput("rst_if_valid", 32'(if_valid), 32'h0);
    checkOutput("rst_if_pc", 32'(if_pc), 32'h0);
    checkOutput("rst_if_instr", if_instr, 32'h0);

    // Reset release: first fetch in cycle 1, first delivery in cycle 3.
    exp_pc = 9'h000; delivered = 0;
    runCycle(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("boot_imem_en", 32'(imem_en), 32'h0);
    checkOutput("boot_if_valid", 32'(if_valid), 32'h0);
    runCycle(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("c1_imem_en", 32'(imem_en), 32'h1);
    checkOutput("c1_imem_addr", 32'(imem_addr), 32'h000);
    runCycle(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("c2_if_valid", 32'(if_valid), 32'h0);
    checkOutput("c2_imem_addr", 32'(imem_addr), 32'h004);
    runCycle(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("c3_if_valid", 32'(if_valid), 32'h1);
    repeat (6) runCycle(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("release_count", 32'(delivered), 32'd7);

    // Backpressure: FIFO fills, fetch stops, address holds, then resumes.
    delivered = 0;
    runCycle(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("bp0_imem_en", 32'(imem_en), 32'h0);
    repeat (3) runCycle(1'b0, 1'b0, 32'h0, 1'b0);
    runCycle(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("bp4_imem_en", 32'(imem_en), 32'h0);
    checkOutput("bp4_if_valid", 32'(if_valid), 32'h1);
    checkOutput("bp4_if_pc", 32'(if_pc), 32'h01C);
    checkOutput("bp4_imem_addr", 32'(imem_addr), 32'h024);
    repeat (6) runCycle(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("bp_count", 32'(delivered), 32'd6);

    // Redirect to 0x43 (low bits dropped) with one buffered, one in flight.
    runCycle(1'b0, 1'b1, 32'h0000_0043, 1'b1);
    checkOutput("redir_if_valid", 32'(if_valid), 32'h0);
    checkOutput("redir_imem_en", 32'(imem_en), 32'h0);
    exp_pc = 9'h040; delivered = 0;
    runCycle(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("redir1_imem_en", 32'(imem_en), 32'h1);
    checkOutput("redir1_imem_addr", 32'(imem_addr), 32'h040);
    checkOutput("redir1_if_valid", 32'(if_valid), 32'h0);
    runCycle(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("redir2_if_valid", 32'(if_valid), 32'h0);
    runCycle(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("redir3_if_valid", 32'(if_valid), 32'h1);
    repeat (5) runCycle(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("redir_count", 32'(delivered), 32'd6);

    // Fill the FIFO, then back-to-back redirects: 0x100 then 0x020.
    runCycle(1'b0, 1'b0, 32'h0, 1'b0);
    runCycle(1'b0, 1'b1, 32'h0000_0100, 1'b0);
    checkOutput("b2b0_if_valid", 32'(if_valid), 32'h0);
    checkOutput("b2b0_imem_en", 32'(imem_en), 32'h0);
    runCycle(1'b0, 1'b1, 32'h0000_0020, 1'b1);
    checkOutput("b2b1_imem_en", 32'(imem_en), 32'h0);
    exp_pc = 9'h020; delivered = 0;
    runCycle(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("b2b2_imem_en", 32'(imem_en), 32'h1);
    checkOutput("b2b2_imem_addr", 32'(imem_addr), 32'h020);
    repeat (7) runCycle(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("b2b_count", 32'(delivered), 32'd6);

    // Wrap-around from 0x1F8; upper target bits must be ignored.
    runCycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    exp_pc = 9'h1F8; delivered = 0;
    repeat (4) runCycle(1'b0, 1'b0, 32'h0, 1'b1);
    runCycle(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("wrap_if_pc", 32'(if_pc), 32'h000);
    repeat (3) runCycle(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("wrap_count", 32'(delivered), 32'd6);

    // Mid-run reset with a full FIFO and a simultaneous redirect.
    runCycle(1'b0, 1'b0, 32'h0, 1'b0);
    runCycle(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("full_imem_en", 32'(imem_en), 32'h0);
    checkOutput("full_if_valid", 32'(if_valid), 32'h1);
    runCycle(1'b1, 1'b1, 32'h0000_0100, 1'b0);
    exp_pc = 9'h000; delivered = 0;
    runCycle(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("mrst_if_valid", 32'(if_valid), 32'h0);
    checkOutput("mrst_imem_en", 32'(imem_en), 32'h0);
    checkOutput("mrst_imem_addr", 32'(imem_addr), 32'h000);
    runCycle(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("mrst1_imem_en", 32'(imem_en), 32'h1);
    checkOutput("mrst1_imem_addr", 32'(imem_addr), 32'h000);
    runCycle(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("mrst2_if_valid", 32'(if_valid), 32'h0);
    runCycle(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("mrst3_if_valid", 32'(if_valid), 32'h1);
    repeat (6) runCycle(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("mrst_count", 32'(delivered), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
